act_accelerator: RTL and testbench

//  Post-processing stage downstream of the dot-product accelerator. The CPU collects dot-product sums
//  (signed Q16.16) into an output-feature-map array in SDRAM. This block reads that array, adds a bias,

---
 rtl/act_pkg.sv | 22 ++
 rtl/act_if.sv | 27 ++
 rtl/act_bias_relu.sv | 30 +++
 rtl/act_accelerator.sv | 152 +++++++++++++++
 tb/tb_act_accelerator.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/act_pkg.sv
// Shared types and constants for the activation post-processing stage.
package act_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_DATA,
      WR_REQ,
      DONE
   } state_t;

   localparam logic [3:0] REG_CTRL = 4'd0;
   localparam logic [3:0] REG_SRC  = 4'd1;
   localparam logic [3:0] REG_DST  = 4'd2;
   localparam logic [3:0] REG_BIAS = 4'd3;
   localparam logic [3:0] REG_LEN  = 4'd4;
   localparam logic [3:0] REG_CFG  = 4'd5;

   localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] Q_MIN = 32'h8000_0000;

endpackage

// File: rtl/act_if.sv
// Avalon-MM links: CPU configuration port and memory data port.
interface act_csr_if #(parameter int DATA_W = 32);
   logic              waitrequest;
   logic [3:0]        address;
   logic              read;
   logic [DATA_W-1:0] readdata;
   logic              write;
   logic [DATA_W-1:0] writedata;

   modport master (input waitrequest, readdata, output address, read, write, writedata);
   modport slave  (output waitrequest, readdata, input address, read, write, writedata);
endinterface

interface act_mem_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic              waitrequest;
   logic [ADDR_W-1:0] address;
   logic              read;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;
   logic              write;
   logic [DATA_W-1:0] writedata;

   modport master (input waitrequest, readdata, readdatavalid,
                   output address, read, write, writedata);
   modport slave  (output waitrequest, readdata, readdatavalid,
                   input address, read, write, writedata);
endinterface

// File: rtl/act_bias_relu.sv
// Q16.16 bias add with saturation and optional ReLU; purely combinational.
module act_bias_relu
   import act_pkg::*;
(
   input  logic [31:0] x,
   input  logic [31:0] bias,
   input  logic        relu_en,
   output logic [31:0] y,
   output logic        clipped
);

   logic [32:0] sum;
   logic [31:0] sat;
   logic        ovf;

   always_comb begin
      sum = {x[31], x} + {bias[31], bias};
      // the two top bits of the sign-extended sum disagree only on overflow
      ovf = sum[32] ^ sum[31];
      if (ovf) sat = sum[32] ? Q_MIN : Q_MAX;
      else     sat = sum[31:0];
      y       = sat;
      clipped = ovf;
      if (relu_en && sat[31]) begin
         y       = '0;
         clipped = 1'b1;
      end
   end

endmodule

// File: rtl/act_accelerator.sv
// Reads a Q16.16 array, adds bias, optional ReLU, writes results; CPU-configured.
module act_accelerator
   import act_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic       clk,
   input logic       rst_n,
   act_csr_if.slave  csr,
   act_mem_if.master mem
);

   // state   | meaning
   // IDLE    | after reset, waiting for start
   // RD_REQ  | read command held until accepted
   // RD_DATA | waiting for readdatavalid, result registered
   // WR_REQ  | write command held until accepted
   // DONE    | job finished, clip count readable

   state_t            state;
   logic [ADDR_W-1:0] cfg_src, cfg_dst, src_w, dst_w;
   logic [DATA_W-1:0] cfg_bias, cfg_len, bias_w, len_w;
   logic              cfg_relu, relu_w;
   logic [DATA_W-1:0] idx, idx_nxt, clip_cnt;
   logic [ADDR_W-1:0] elem_off, nxt_off;
   logic              csr_wr, csr_rd, start;
   logic [DATA_W-1:0] y;
   logic              clipped;

   assign csr_wr   = csr.write && !csr.waitrequest;
   assign csr_rd   = csr.read  && !csr.waitrequest;
   assign start    = csr_wr && (csr.address == REG_CTRL);
   assign idx_nxt  = idx + DATA_W'(1);
   assign elem_off = ADDR_W'(idx) << 2;
   assign nxt_off  = ADDR_W'(idx_nxt) << 2;

   act_bias_relu u_bias_relu (
      .x       (mem.readdata),
      .bias    (bias_w),
      .relu_en (relu_w),
      .y       (y),
      .clipped (clipped)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_src  <= '0;
         cfg_dst  <= '0;
         cfg_bias <= '0;
         cfg_len  <= '0;
         cfg_relu <= 1'b0;
      end else if (csr_wr) begin
         case (csr.address)
            REG_SRC:  cfg_src  <= csr.writedata[ADDR_W-1:0];
            REG_DST:  cfg_dst  <= csr.writedata[ADDR_W-1:0];
            REG_BIAS: cfg_bias <= csr.writedata;
            REG_LEN:  cfg_len  <= csr.writedata;
            REG_CFG:  cfg_relu <= csr.writedata[0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csr.readdata <= '0;
      end else if (csr_rd) begin
         case (csr.address)
            REG_CTRL: csr.readdata <= clip_cnt;
            REG_SRC:  csr.readdata <= DATA_W'(cfg_src);
            REG_DST:  csr.readdata <= DATA_W'(cfg_dst);
            REG_BIAS: csr.readdata <= cfg_bias;
            REG_LEN:  csr.readdata <= cfg_len;
            REG_CFG:  csr.readdata <= DATA_W'(cfg_relu);
            default:  csr.readdata <= '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         csr.waitrequest <= 1'b1;
         mem.read        <= 1'b0;
         mem.write       <= 1'b0;
         mem.address     <= '0;
         mem.writedata   <= '0;
         src_w           <= '0;
         dst_w           <= '0;
         bias_w          <= '0;
         len_w           <= '0;
         relu_w          <= 1'b0;
         idx             <= '0;
         clip_cnt        <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               csr.waitrequest <= 1'b0;
               if (start) begin
                  src_w    <= cfg_src;
                  dst_w    <= cfg_dst;
                  bias_w   <= cfg_bias;
                  len_w    <= cfg_len;
                  relu_w   <= cfg_relu;
                  idx      <= '0;
                  clip_cnt <= '0;
                  if (cfg_len == '0) begin
                     state <= DONE;
                  end else begin
                     state           <= RD_REQ;
                     csr.waitrequest <= 1'b1;
                     mem.read        <= 1'b1;
                     mem.address     <= cfg_src;
                  end
               end
            end
            RD_REQ: begin
               if (!mem.waitrequest) begin
                  mem.read <= 1'b0;
                  state    <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (mem.readdatavalid) begin
                  mem.writedata <= y;
                  clip_cnt      <= clip_cnt + DATA_W'(clipped);
                  mem.write     <= 1'b1;
                  mem.address   <= dst_w + elem_off;
                  state         <= WR_REQ;
               end
            end
            WR_REQ: begin
               if (!mem.waitrequest) begin
                  mem.write <= 1'b0;
                  idx       <= idx_nxt;
                  if (idx_nxt == len_w) begin
                     state           <= DONE;
                     csr.waitrequest <= 1'b0;
                  end else begin
                     state       <= RD_REQ;
                     mem.read    <= 1'b1;
                     mem.address <= src_w + nxt_off;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_act_accelerator.sv
// Bench for act_accelerator: memory responder with random timing plus arithmetic reference model.
module tb_act_accelerator;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   act_csr_if csr ();
   act_mem_if mem ();

   act_accelerator dut (.clk(clk), .rst_n(rst_n), .csr(csr), .mem(mem));

   logic [31:0] u_x, u_b, u_y;
   logic        u_relu, u_clip;
   act_bias_relu u_br (.x(u_x), .bias(u_b), .relu_en(u_relu), .y(u_y), .clipped(u_clip));

   int total = 0;
   int bad = 0;

   logic [31:0] mem_arr [logic [31:0]];
   int  max_wait = 0;
   int  max_rdv = 1;
   bit  spur_en = 1'b0;
   int  wr_acc = 0;
   int  strobe_cnt = 0;
   int  both_high = 0;

   logic [31:0] xs[$];
   logic [31:0] exp_y[$];
   int          exp_clip;
   logic [31:0] cur_src, cur_dst, cur_bias;
   int          cur_len;
   bit          cur_relu;

   function automatic logic [32:0] ref_f(input logic [31:0] x, input logic [31:0] b, input bit relu);
      longint s;
      bit     c;
      s = longint'($signed(x)) + longint'($signed(b));
      c = 1'b0;
      if (s > 64'sd2147483647) begin s = 64'sd2147483647; c = 1'b1; end
      else if (s < -64'sd2147483648) begin s = -64'sd2147483648; c = 1'b1; end
      if (relu && s < 0) begin s = 0; c = 1'b1; end
      return {c, s[31:0]};
   endfunction

   // memory slave: random command stall, random read latency, optional stray readdatavalid
   initial begin : responder
      bit          in_cmd, rd_pend;
      int          wcnt, rd_cnt;
      logic [31:0] rd_val;
      in_cmd = 0; rd_pend = 0; wcnt = 0; rd_cnt = 0; rd_val = '0;
      mem.waitrequest = 1'b0; mem.readdatavalid = 1'b0; mem.readdata = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_cmd = 0; rd_pend = 0;
            mem.waitrequest = 1'b0; mem.readdatavalid = 1'b0;
            continue;
         end
         mem.readdatavalid = 1'b0;
         if (rd_pend) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               mem.readdatavalid = 1'b1; mem.readdata = rd_val; rd_pend = 0;
            end
         end else if (spur_en && $urandom_range(0, 3) == 0) begin
            mem.readdatavalid = 1'b1; mem.readdata = $urandom;
         end
         if (mem.read || mem.write) begin
            if (!in_cmd) begin in_cmd = 1; wcnt = $urandom_range(0, max_wait); end
            if (wcnt > 0) begin
               mem.waitrequest = 1'b1; wcnt--;
            end else begin
               mem.waitrequest = 1'b0; in_cmd = 0;
               if (mem.write) begin
                  mem_arr[mem.address] = mem.writedata; wr_acc++;
               end else begin
                  rd_pend = 1; rd_cnt = $urandom_range(1, max_rdv);
                  rd_val = mem_arr.exists(mem.address) ? mem_arr[mem.address] : 32'hDEAD_BEEF;
               end
            end
         end else begin
            mem.waitrequest = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (mem.read && mem.write) both_high++;
      if (mem.read || mem.write) strobe_cnt++;
   end

   task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
      int n;
      n = 0;
      @(negedge clk);
      csr.address = a; csr.writedata = d; csr.write = 1'b1;
      while (csr.waitrequest && n < 20000) begin @(negedge clk); n++; end
      if (csr.waitrequest) begin
         total++; bad++;
         $display("FAIL csr_write_timeout addr=%0d waitrequest=%b required=0", a, csr.waitrequest);
      end
      @(negedge clk);
      csr.write = 1'b0;
   endtask

   task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
      int n;
      n = 0;
      @(negedge clk);
      csr.address = a; csr.read = 1'b1;
      while (csr.waitrequest && n < 20000) begin @(negedge clk); n++; end
      if (csr.waitrequest) begin
         total++; bad++;
         $display("FAIL csr_read_timeout addr=%0d waitrequest=%b required=0", a, csr.waitrequest);
      end
      @(negedge clk);
      csr.read = 1'b0;
      d = csr.readdata;
   endtask

   task automatic job_setup(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] bias,
                            input int len, input bit relu);
      logic [32:0] r;
      logic [31:0] a;
      cur_src = src; cur_dst = dst; cur_bias = bias; cur_len = len; cur_relu = relu;
      exp_y.delete();
      exp_clip = 0;
      for (int i = 0; i < len; i++) begin
         a = src + 32'(4 * i); mem_arr[a] = xs[i];
         a = dst + 32'(4 * i); mem_arr[a] = 32'hA5A5_A5A5;
         r = ref_f(xs[i], bias, relu);
         exp_y.push_back(r[31:0]);
         exp_clip += int'(r[32]);
      end
      csr_write(4'd1, src);
      csr_write(4'd2, dst);
      csr_write(4'd3, bias);
      csr_write(4'd4, 32'(len));
      csr_write(4'd5, {31'd0, relu});
   endtask

   task automatic start_job(output int cyc);
      csr_write(4'd0, 32'd1);
      cyc = 0;
      while (csr.waitrequest && cyc < 20000) begin @(negedge clk); cyc++; end
      if (csr.waitrequest) begin
         total++; bad++;
         $display("FAIL job_timeout waitrequest=%b required=0", csr.waitrequest);
      end
   endtask

   task automatic random_xs(input int len);
      xs.delete();
      for (int i = 0; i < len; i++) xs.push_back($urandom);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      repeat (2) @(negedge clk);
      total++; if (csr.waitrequest !== 1'b1) begin bad++; $display("FAIL rst_waitrequest got=%b exp=1", csr.waitrequest); end
      total++; if (mem.read !== 1'b0) begin bad++; $display("FAIL rst_read got=%b exp=0", mem.read); end
      total++; if (mem.write !== 1'b0) begin bad++; $display("FAIL rst_write got=%b exp=0", mem.write); end
      total++; if (mem.address !== 32'h0) begin bad++; $display("FAIL rst_address got=%h exp=0", mem.address); end
      total++; if (mem.writedata !== 32'h0) begin bad++; $display("FAIL rst_writedata got=%h exp=0", mem.writedata); end
      total++; if (csr.readdata !== 32'h0) begin bad++; $display("FAIL rst_readdata got=%h exp=0", csr.readdata); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (csr.waitrequest !== 1'b0) begin bad++; $display("FAIL idle_waitrequest got=%b exp=0", csr.waitrequest); end
      csr_read(4'd0, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_clip got=%h exp=0", d); end
   endtask

   task automatic test_bias_relu_unit();
      logic [32:0] r;
      logic [31:0] vx[4] = '{32'h7FFF_0000, 32'h8000_0000, 32'h0001_0000, 32'hFFFF_0000};
      logic [31:0] vb[4] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0000_8000};
      logic [32:0] ve[4] = '{{1'b1, 32'h7FFF_FFFF}, {1'b1, 32'h8000_0000},
                             {1'b0, 32'h0001_8000}, {1'b0, 32'hFFFF_8000}};
      for (int i = 0; i < 4; i++) begin
         u_x = vx[i]; u_b = vb[i]; u_relu = 1'b0; #1;
         total++;
         if ({u_clip, u_y} !== ve[i]) begin
            bad++; $display("FAIL unit_fixed[%0d] got=%b/%h exp=%b/%h", i, u_clip, u_y, ve[i][32], ve[i][31:0]);
         end
      end
      for (int i = 0; i < 200; i++) begin
         u_x = $urandom; u_b = $urandom; u_relu = 1'($urandom_range(0, 1));
         if (i % 4 == 0) u_b = u_x;
         #1;
         r = ref_f(u_x, u_b, u_relu);
         total++;
         if ({u_clip, u_y} !== r) begin
            bad++; $display("FAIL unit_rand x=%h b=%h relu=%b got=%b/%h exp=%b/%h",
                            u_x, u_b, u_relu, u_clip, u_y, r[32], r[31:0]);
         end
      end
   endtask

   task automatic test_basic(input bit relu);
      logic [31:0] spec_y[3];
      logic [31:0] d;
      int          cyc;
      spec_y = '{32'h0001_8000, relu ? 32'h0 : 32'hFFFF_8000, 32'h0003_0000};
      xs = '{32'h0001_0000, 32'hFFFF_0000, 32'h0002_8000};
      job_setup(32'h0000_1000, 32'h0000_2000, 32'h0000_8000, 3, relu);
      start_job(cyc);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (mem_arr[32'h2000 + 32'(4 * i)] !== spec_y[i]) begin
            bad++; $display("FAIL basic_relu%0d_dst[%0d] got=%h exp=%h", relu, i, mem_arr[32'h2000 + 32'(4 * i)], spec_y[i]);
         end
      end
      csr_read(4'd0, d);
      total++;
      if (d !== (relu ? 32'd1 : 32'd0)) begin bad++; $display("FAIL basic_relu%0d_clip got=%0d exp=%0d", relu, d, relu); end
   endtask

   task automatic test_saturation();
      logic [31:0] d;
      int          cyc;
      xs = '{32'h7FFF_0000};
      job_setup(32'h0000_3000, 32'h0000_4000, 32'h0001_0000, 1, 1'b0);
      start_job(cyc);
      total++; if (mem_arr[32'h4000] !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sat_pos got=%h exp=7fffffff", mem_arr[32'h4000]); end
      csr_read(4'd0, d);
      total++; if (d !== 32'd1) begin bad++; $display("FAIL sat_pos_clip got=%0d exp=1", d); end
      xs = '{32'h8000_0000};
      job_setup(32'h0000_3000, 32'h0000_4000, 32'hFFFF_0000, 1, 1'b0);
      start_job(cyc);
      total++; if (mem_arr[32'h4000] !== 32'h8000_0000) begin bad++; $display("FAIL sat_neg got=%h exp=80000000", mem_arr[32'h4000]); end
      csr_read(4'd0, d);
      total++; if (d !== 32'd1) begin bad++; $display("FAIL sat_neg_clip got=%0d exp=1", d); end
   endtask

   task automatic test_zero_len();
      logic [31:0] d;
      int          cyc, s0;
      xs.delete();
      job_setup(32'h0000_5000, 32'h0000_6000, 32'h0000_0001, 0, 1'b1);
      s0 = strobe_cnt;
      start_job(cyc);
      total++; if (cyc > 1) begin bad++; $display("FAIL zero_len_cycles got=%0d exp<=1", cyc); end
      total++; if (csr.waitrequest !== 1'b0) begin bad++; $display("FAIL zero_len_wait got=%b exp=0", csr.waitrequest); end
      repeat (3) @(negedge clk);
      total++; if (strobe_cnt != s0) begin bad++; $display("FAIL zero_len_strobes got=%0d exp=0", strobe_cnt - s0); end
      csr_read(4'd0, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL zero_len_clip got=%0d exp=0", d); end
   endtask

   task automatic test_random_job(input string tag, input logic [31:0] src, input logic [31:0] dst, input int len);
      logic [31:0] d, a;
      int          cyc;
      random_xs(len);
      job_setup(src, dst, $urandom, len, 1'($urandom_range(0, 1)));
      start_job(cyc);
      for (int i = 0; i < len; i++) begin
         a = dst + 32'(4 * i);
         total++;
         if (mem_arr[a] !== exp_y[i]) begin
            bad++; $display("FAIL %s_dst[%0d] got=%h exp=%h", tag, i, mem_arr[a], exp_y[i]);
         end
      end
      csr_read(4'd0, d);
      total++;
      if (d !== 32'(exp_clip)) begin bad++; $display("FAIL %s_clip got=%0d exp=%0d", tag, d, exp_clip); end
   endtask

   task automatic test_random_timing();
      max_wait = 5; max_rdv = 8; spur_en = 1'b1;
      test_basic(1'b1);
      test_random_job("wrap", 32'hFFFF_FFF8, 32'h0000_7000, 4);
      for (int k = 0; k < 6; k++)
         test_random_job("rand", 32'h1000_0000 + 32'($urandom_range(0, 15) << 8),
                         32'h2000_0000 + 32'($urandom_range(0, 15) << 8), $urandom_range(1, 8));
   endtask

   task automatic test_rerun();
      logic [31:0] d, a;
      int          cyc;
      for (int i = 0; i < cur_len; i++) mem_arr[cur_dst + 32'(4 * i)] = 32'hA5A5_A5A5;
      start_job(cyc);
      for (int i = 0; i < cur_len; i++) begin
         a = cur_dst + 32'(4 * i);
         total++;
         if (mem_arr[a] !== exp_y[i]) begin bad++; $display("FAIL rerun_dst[%0d] got=%h exp=%h", i, mem_arr[a], exp_y[i]); end
      end
      csr_read(4'd0, d);
      total++; if (d !== 32'(exp_clip)) begin bad++; $display("FAIL rerun_clip got=%0d exp=%0d", d, exp_clip); end
   endtask

   task automatic test_busy_stall();
      logic [31:0] a, nb;
      logic [32:0] r;
      int          w0, cyc;
      random_xs(6);
      job_setup(32'h0000_8000, 32'h0000_9000, $urandom, 6, 1'b1);
      w0 = wr_acc;
      csr_write(4'd0, 32'd1);
      nb = $urandom;
      csr_write(4'd3, nb);
      total++;
      if (wr_acc - w0 != 6) begin bad++; $display("FAIL busy_stall_writes got=%0d exp=6", wr_acc - w0); end
      for (int i = 0; i < 6; i++) begin
         a = 32'h9000 + 32'(4 * i);
         total++;
         if (mem_arr[a] !== exp_y[i]) begin bad++; $display("FAIL busy_old_bias[%0d] got=%h exp=%h", i, mem_arr[a], exp_y[i]); end
         mem_arr[a] = 32'hA5A5_A5A5;
      end
      start_job(cyc);
      for (int i = 0; i < 6; i++) begin
         a = 32'h9000 + 32'(4 * i);
         r = ref_f(xs[i], nb, 1'b1);
         total++;
         if (mem_arr[a] !== r[31:0]) begin bad++; $display("FAIL busy_new_bias[%0d] got=%h exp=%h", i, mem_arr[a], r[31:0]); end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      int          n, cyc, s0;
      random_xs(8);
      job_setup(32'h0000_A000, 32'h0000_B000, $urandom, 8, 1'b0);
      csr_write(4'd0, 32'd1);
      n = 0;
      while (!mem.write && n < 2000) begin @(negedge clk); n++; end
      total++;
      if (!mem.write) begin bad++; $display("FAIL reset_mid_no_write got=%b exp=1", mem.write); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (mem.write !== 1'b0) begin bad++; $display("FAIL reset_mid_write got=%b exp=0", mem.write); end
      total++; if (csr.waitrequest !== 1'b1) begin bad++; $display("FAIL reset_mid_wait got=%b exp=1", csr.waitrequest); end
      total++; if (mem.read !== 1'b0) begin bad++; $display("FAIL reset_mid_read got=%b exp=0", mem.read); end
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      s0 = strobe_cnt;
      start_job(cyc);
      repeat (3) @(negedge clk);
      total++; if (strobe_cnt != s0) begin bad++; $display("FAIL reset_cfg_cleared strobes=%0d exp=0", strobe_cnt - s0); end
      total++; if (cyc > 1) begin bad++; $display("FAIL reset_cfg_len cycles=%0d exp<=1", cyc); end
      csr_read(4'd0, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_clip got=%0d exp=0", d); end
      test_random_job("post_reset", 32'h0000_C000, 32'h0000_D000, 5);
   endtask

   initial begin
      csr.address = '0; csr.read = 1'b0; csr.write = 1'b0; csr.writedata = '0;
      u_x = '0; u_b = '0; u_relu = 1'b0;
      test_reset();
      test_bias_relu_unit();
      test_basic(1'b1);
      test_basic(1'b0);
      test_saturation();
      test_zero_len();
      test_random_timing();
      test_rerun();
      test_busy_stall();
      test_reset_mid();
      total++;
      if (both_high != 0) begin bad++; $display("FAIL read_write_overlap got=%0d exp=0", both_high); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
